banner_screen: RTL and testbench
================================

# banner_screen

Parametrised message banner renderer for the lane-runner VGA path; next generation of the single-purpose end-of-game letter drawer. On a rising edge of `enable` from the master FSM it rasterises one of four built-in five-character messages from a 5x7 glyph ROM, scaled per axis, in staircase (one character per lane, stepping down) or horizontal-row layout. It drives the shared pixel-write bus one pixel per clock and reports `showing`/`complete` back to the master FSM.

## Interface
- NUM_LANES, 5: characters per message (one per lane).
- LANE_WIDTH, 80: lane pitch in pixels.
- LANE_START_X, 120: x of lane 0 left edge.
- START_Y, 200: y of character 0 top edge.
- STEP_Y, 50: per-character y step in staircase layout.
- SCALE_X, 8: pixels per glyph column; cell width CW = 5*SCALE_X.
- SCALE_Y, 7: pixels per glyph row; cell height CH = 7*SCALE_Y.
- BG_COLOR, 9'b000_000_000: colour of off pixels.
- Clock  in  1  system clock; all state on rising edge.
- Resetn  in  1  asynchronous, active-low reset.
- enable  in  1  level request from master FSM; rising edge starts a draw.
- msg_sel  in  2  message: 0 "LOSER", 1 "WIN  ", 2 "READY", 3 "PAUSE"; latched at start.
- layout  in  1  0 staircase, 1 horizontal row; latched at start.
- fg_color  in  9  on-pixel colour; latched at start.
- erase  in  1  clear request; latched at start (used only with BANNER_ERASE_EN).
- showing  out  1  high while drawing.
- complete  out  1  high from end of draw until `enable` falls.
- VGA_x  out  10  pixel x.  VGA_y  out  9  pixel y.  VGA_color  out  9  pixel colour.
- VGA_write  out  1  pixel write strobe.

## Operation
- States IDLE, DRAW, DONE. Reset: state IDLE, all outputs 0, enable_prev 0, counters 0.
- enable_prev registers `enable` every cycle; start = enable & ~enable_prev.
- IDLE: counters cleared, outputs low. On start: latch msg_sel/layout/fg_color/erase, showing<=1, go DRAW.
- DRAW: counters char c (0..NUM_LANES-1), row py (0..CH-1), column px (0..CW-1); px fastest, then py, then c.
- Cell origin: x0 = LANE_START_X + c*LANE_WIDTH + (LANE_WIDTH-CW)/2; y0 = START_Y + c*STEP_Y (staircase) or START_Y (horizontal).
- Each DRAW cycle registers VGA_x = x0+px, VGA_y = y0+py, VGA_write = 1, VGA_color = fg_color if glyph bit set else BG_COLOR.
- Glyph bit: ROM[char][py/SCALE_Y] bit (4 - px/SCALE_X); bit 4 = leftmost column. Space glyph all zero, still fully drawn (fixed latency).
- Glyphs required: L O S E R W I N A D Y P U space.
- After last pixel (c=NUM_LANES-1, py=CH-1, px=CW-1) issued: go DONE; that pixel's write is not dropped.
- DONE: VGA_write 0, showing 0, complete 1; when enable=0, complete<=0, go IDLE.
- enable falling during DRAW: abort; next cycle IDLE, VGA_write 0, showing 0, complete never asserted.
- Coordinate sums truncate to 10/9 bits; off-screen configuration is the integrator's responsibility.
- Asynchronous reset mid-draw: all outputs 0 immediately, IDLE; a new draw requires a fresh rising edge of enable.

## Timing
- Start seen at edge k: showing high after k; first VGA_write high after k+1.
- VGA_write high for exactly NUM_LANES*CW*CH consecutive cycles (9800 at defaults), no gaps.
- complete rises on the same edge VGA_write falls; showing falls on that edge.
- enable held high in DONE: no restart; must go low at least one cycle first.
- Inputs latched only at start; changes during DRAW are ignored.

## Configuration
- BANNER_ERASE_EN defined: if erase latched 1, every pixel written BG_COLOR (same addresses, same count) to clear the banner.
- Undefined: `erase` ignored; glyph drawn normally.

## Test plan
- Defaults, msg_sel=0, layout=0, fg=9'h1C0, pulse enable -> 9800 writes; first (140,200) colour 9'h1C0; char 4 first pixel (460,400); complete 1 cycle after last write.
- msg_sel=1, layout=1 -> all cells y 200..248; chars 3,4 (x 380..419, 460..499) all BG_COLOR.
- Drop enable after 100 writes -> VGA_write 0 next cycle, complete stays 0; re-raise -> full 9800-write redraw from (140,200).
- Hold enable through DONE 50 cycles -> no writes, complete 1; drop -> complete 0 next cycle.
- Assert Resetn low mid-draw asynchronously -> outputs 0 before next edge; release with enable high -> no draw until enable toggles.
- BANNER_ERASE_EN, erase=1 -> 9800 writes all BG_COLOR; without macro same stimulus -> glyph colours.

Source files
------------

// File: rtl/banner_screen.sv
`default_nettype none
// ============================================================================
//  Module      : banner_screen
//  Description : Message banner renderer for the lane-runner VGA path.
//                On a rising edge of enable it rasterises one of four
//                five-character messages from a 5x7 glyph ROM, scaled per
//                axis, in staircase or horizontal layout, one pixel per
//                clock onto the shared pixel-write bus.
//                Optional feature macro: BANNER_ERASE_EN (when defined, a
//                latched erase request paints every pixel BG_COLOR).
//  Revision    : 1.0 - initial release
// ============================================================================
module banner_screen #(
    parameter int         NUM_LANES    = 5,
    parameter int         LANE_WIDTH   = 80,
    parameter int         LANE_START_X = 120,
    parameter int         START_Y      = 200,
    parameter int         STEP_Y       = 50,
    parameter int         SCALE_X      = 8,
    parameter int         SCALE_Y      = 7,
    parameter logic [8:0] BG_COLOR     = 9'b000_000_000
) (
    input  logic       Clock,
    input  logic       Resetn,
    input  logic       enable,
    input  logic [1:0] msg_sel,
    input  logic       layout,
    input  logic [8:0] fg_color,
    input  logic       erase,
    output logic       showing,
    output logic       complete,
    output logic [9:0] VGA_x,
    output logic [8:0] VGA_y,
    output logic [8:0] VGA_color,
    output logic       VGA_write
);

    // Cell geometry
    localparam int CW    = 5 * SCALE_X;
    localparam int CH    = 7 * SCALE_Y;
    localparam int X_PAD = (LANE_WIDTH - CW) / 2;

    // Counter widths
    localparam int C_W  = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
    localparam int PX_W = $clog2(CW + 1);
    localparam int PY_W = $clog2(CH + 1);
    localparam int SX_W = $clog2(SCALE_X + 1);
    localparam int SY_W = $clog2(SCALE_Y + 1);

    // Glyph codes
    localparam logic [3:0] G_SP = 4'd0;
    localparam logic [3:0] G_L  = 4'd1;
    localparam logic [3:0] G_O  = 4'd2;
    localparam logic [3:0] G_S  = 4'd3;
    localparam logic [3:0] G_E  = 4'd4;
    localparam logic [3:0] G_R  = 4'd5;
    localparam logic [3:0] G_W  = 4'd6;
    localparam logic [3:0] G_I  = 4'd7;
    localparam logic [3:0] G_N  = 4'd8;
    localparam logic [3:0] G_A  = 4'd9;
    localparam logic [3:0] G_D  = 4'd10;
    localparam logic [3:0] G_Y  = 4'd11;
    localparam logic [3:0] G_P  = 4'd12;
    localparam logic [3:0] G_U  = 4'd13;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DRAW = 2'd1,
        DONE = 2'd2
    } state_t;

    // Character code at position idx of message sel; positions past the
    // fifth character render as space so extra lanes are still drawn.
    function automatic logic [3:0] msg_char(input logic [1:0] sel, input int idx);
        logic [19:0] word;
        case (sel)
            2'd0:    word = {G_L, G_O, G_S, G_E, G_R};
            2'd1:    word = {G_W, G_I, G_N, G_SP, G_SP};
            2'd2:    word = {G_R, G_E, G_A, G_D, G_Y};
            default: word = {G_P, G_A, G_U, G_S, G_E};
        endcase
        if (idx < 0 || idx > 4) begin
            return G_SP;
        end
        return 4'(word >> (4 * (4 - idx)));
    endfunction

    // 5x7 glyph ROM: row 0 (top) in bits [34:30], bit 4 of a row = leftmost.
    function automatic logic [34:0] glyph_bits(input logic [3:0] code);
        case (code)
            G_L: return 35'b10000_10000_10000_10000_10000_10000_11111;
            G_O: return 35'b01110_10001_10001_10001_10001_10001_01110;
            G_S: return 35'b01111_10000_10000_01110_00001_00001_11110;
            G_E: return 35'b11111_10000_10000_11110_10000_10000_11111;
            G_R: return 35'b11110_10001_10001_11110_10100_10010_10001;
            G_W: return 35'b10001_10001_10001_10101_10101_10101_01010;
            G_I: return 35'b01110_00100_00100_00100_00100_00100_01110;
            G_N: return 35'b10001_11001_10101_10011_10001_10001_10001;
            G_A: return 35'b01110_10001_10001_11111_10001_10001_10001;
            G_D: return 35'b11110_10001_10001_10001_10001_10001_11110;
            G_Y: return 35'b10001_10001_01010_00100_00100_00100_00100;
            G_P: return 35'b11110_10001_10001_11110_10000_10000_10000;
            G_U: return 35'b10001_10001_10001_10001_10001_10001_01110;
            default: return 35'd0;
        endcase
    endfunction

    // State and counters
    state_t          state_q, state_d;
    logic            enable_prev_q, enable_prev_d;
    logic            arm_q, arm_d;
    logic [C_W-1:0]  c_q, c_d;
    logic [PX_W-1:0] px_q, px_d;
    logic [PY_W-1:0] py_q, py_d;
    logic [SX_W-1:0] sx_q, sx_d;
    logic [SY_W-1:0] sy_q, sy_d;
    logic [2:0]      gx_q, gx_d;
    logic [2:0]      gy_q, gy_d;

    // Latched request
    logic [1:0]      msg_q, msg_d;
    logic            layout_q, layout_d;
    logic [8:0]      fg_q, fg_d;
`ifdef BANNER_ERASE_EN
    logic            erase_q, erase_d;
`endif

    // Registered outputs
    logic            showing_q, showing_d;
    logic            complete_q, complete_d;
    logic [9:0]      vga_x_q, vga_x_d;
    logic [8:0]      vga_y_q, vga_y_d;
    logic [8:0]      vga_color_q, vga_color_d;
    logic            vga_write_q, vga_write_d;

    // Combinational helpers
    logic            w_start;
    logic [3:0]      w_char;
    logic [34:0]     w_glyph;
    logic [4:0]      w_row;
    logic            w_bit;
    logic            w_on;
    logic [9:0]      w_pix_x;
    logic [8:0]      w_pix_y;
    logic            w_px_last;
    logic            w_py_last;
    logic            w_c_last;

    // arm_q blocks a start until enable has been seen low after reset, so
    // releasing reset with enable already high does not launch a draw.
    assign w_start = enable & ~enable_prev_q & arm_q;

    // Glyph lookup for the pixel currently addressed by the counters
    assign w_char  = msg_char(msg_q, int'(c_q));
    assign w_glyph = glyph_bits(w_char);
    assign w_row   = 5'(w_glyph >> (5 * (6 - int'(gy_q))));
    assign w_bit   = w_row[3'd4 - gx_q];

`ifdef BANNER_ERASE_EN
    assign w_on = w_bit & ~erase_q;
`else
    logic unused_erase;
    assign unused_erase = erase;
    assign w_on = w_bit;
`endif

    // Screen coordinates of the current pixel; sums wrap to bus width
    assign w_pix_x = 10'(LANE_START_X + X_PAD) + 10'(c_q) * 10'(LANE_WIDTH) + 10'(px_q);
    assign w_pix_y = 9'(START_Y) + (layout_q ? 9'd0 : 9'(c_q) * 9'(STEP_Y)) + 9'(py_q);

    assign w_px_last = (px_q == PX_W'(CW - 1));
    assign w_py_last = (py_q == PY_W'(CH - 1));
    assign w_c_last  = (c_q  == C_W'(NUM_LANES - 1));

    // Next-state logic for the draw FSM, raster counters and outputs
    always_comb begin
        state_d       = state_q;
        enable_prev_d = enable;
        arm_d         = arm_q | ~enable;
        c_d           = c_q;
        px_d          = px_q;
        py_d          = py_q;
        sx_d          = sx_q;
        sy_d          = sy_q;
        gx_d          = gx_q;
        gy_d          = gy_q;
        msg_d         = msg_q;
        layout_d      = layout_q;
        fg_d          = fg_q;
`ifdef BANNER_ERASE_EN
        erase_d       = erase_q;
`endif
        showing_d     = showing_q;
        complete_d    = complete_q;
        vga_x_d       = '0;
        vga_y_d       = '0;
        vga_color_d   = '0;
        vga_write_d   = 1'b0;

        case (state_q)
            IDLE: begin
                c_d        = '0;
                px_d       = '0;
                py_d       = '0;
                sx_d       = '0;
                sy_d       = '0;
                gx_d       = '0;
                gy_d       = '0;
                showing_d  = 1'b0;
                complete_d = 1'b0;
                if (w_start) begin
                    msg_d     = msg_sel;
                    layout_d  = layout;
                    fg_d      = fg_color;
`ifdef BANNER_ERASE_EN
                    erase_d   = erase;
`endif
                    showing_d = 1'b1;
                    state_d   = DRAW;
                end
            end

            DRAW: begin
                if (!enable) begin
                    // Abort: the master FSM withdrew the request mid-draw
                    showing_d = 1'b0;
                    state_d   = IDLE;
                end else begin
                    vga_x_d     = w_pix_x;
                    vga_y_d     = w_pix_y;
                    vga_color_d = w_on ? fg_q : BG_COLOR;
                    vga_write_d = 1'b1;

                    // px fastest, then py, then character; sx/sy track
                    // position within a scaled glyph cell so no divide is
                    // needed to find the glyph column/row.
                    if (w_px_last) begin
                        px_d = '0;
                        sx_d = '0;
                        gx_d = '0;
                        if (w_py_last) begin
                            py_d = '0;
                            sy_d = '0;
                            gy_d = '0;
                            if (w_c_last) begin
                                c_d     = '0;
                                state_d = DONE;
                            end else begin
                                c_d = c_q + C_W'(1);
                            end
                        end else begin
                            py_d = py_q + PY_W'(1);
                            if (sy_q == SY_W'(SCALE_Y - 1)) begin
                                sy_d = '0;
                                gy_d = gy_q + 3'd1;
                            end else begin
                                sy_d = sy_q + SY_W'(1);
                            end
                        end
                    end else begin
                        px_d = px_q + PX_W'(1);
                        if (sx_q == SX_W'(SCALE_X - 1)) begin
                            sx_d = '0;
                            gx_d = gx_q + 3'd1;
                        end else begin
                            sx_d = sx_q + SX_W'(1);
                        end
                    end
                end
            end

            DONE: begin
                showing_d  = 1'b0;
                complete_d = 1'b1;
                if (!enable) begin
                    complete_d = 1'b0;
                    state_d    = IDLE;
                end
            end

            default: begin
                showing_d  = 1'b0;
                complete_d = 1'b0;
                state_d    = IDLE;
            end
        endcase
    end

    // All state registers, asynchronously cleared
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q       <= IDLE;
            enable_prev_q <= 1'b0;
            arm_q         <= 1'b0;
            c_q           <= '0;
            px_q          <= '0;
            py_q          <= '0;
            sx_q          <= '0;
            sy_q          <= '0;
            gx_q          <= '0;
            gy_q          <= '0;
            msg_q         <= '0;
            layout_q      <= 1'b0;
            fg_q          <= '0;
`ifdef BANNER_ERASE_EN
            erase_q       <= 1'b0;
`endif
            showing_q     <= 1'b0;
            complete_q    <= 1'b0;
            vga_x_q       <= '0;
            vga_y_q       <= '0;
            vga_color_q   <= '0;
            vga_write_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            enable_prev_q <= enable_prev_d;
            arm_q         <= arm_d;
            c_q           <= c_d;
            px_q          <= px_d;
            py_q          <= py_d;
            sx_q          <= sx_d;
            sy_q          <= sy_d;
            gx_q          <= gx_d;
            gy_q          <= gy_d;
            msg_q         <= msg_d;
            layout_q      <= layout_d;
            fg_q          <= fg_d;
`ifdef BANNER_ERASE_EN
            erase_q       <= erase_d;
`endif
            showing_q     <= showing_d;
            complete_q    <= complete_d;
            vga_x_q       <= vga_x_d;
            vga_y_q       <= vga_y_d;
            vga_color_q   <= vga_color_d;
            vga_write_q   <= vga_write_d;
        end
    end

    assign showing   = showing_q;
    assign complete  = complete_q;
    assign VGA_x     = vga_x_q;
    assign VGA_y     = vga_y_q;
    assign VGA_color = vga_color_q;
    assign VGA_write = vga_write_q;

endmodule
`default_nettype wire

// File: tb/tb_banner_screen.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_banner_screen
//  Description : Scoreboard bench for banner_screen at default parameters.
//                Honours BANNER_ERASE_EN for the expected erase colours.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_banner_screen;

    logic       Clock = 1'b0;
    logic       Resetn = 1'b0;
    logic       enable = 1'b0;
    logic [1:0] msg_sel = 2'd0;
    logic       layout = 1'b0;
    logic [8:0] fg_color = 9'd0;
    logic       erase = 1'b0;
    logic       showing;
    logic       complete;
    logic [9:0] VGA_x;
    logic [8:0] VGA_y;
    logic [8:0] VGA_color;
    logic       VGA_write;

    banner_screen dut (
        .Clock     (Clock),
        .Resetn    (Resetn),
        .enable    (enable),
        .msg_sel   (msg_sel),
        .layout    (layout),
        .fg_color  (fg_color),
        .erase     (erase),
        .showing   (showing),
        .complete  (complete),
        .VGA_x     (VGA_x),
        .VGA_y     (VGA_y),
        .VGA_color (VGA_color),
        .VGA_write (VGA_write)
    );

    always #5 Clock = ~Clock;

    typedef struct packed {
        logic [9:0] x;
        logic [8:0] y;
        logic [8:0] c;
    } pix_t;

    pix_t exp_q[$];
    pix_t mon_e;
    int   checks   = 0;
    int   errors   = 0;
    int   wr_count = 0;
    bit   abort_ok = 1'b0;
    bit   in_burst = 1'b0;

    // Message text and glyph art ('#' = lit), written from the glyph shapes
    function automatic string msg_text(input int m);
        case (m)
            0:       return "LOSER";
            1:       return "WIN  ";
            2:       return "READY";
            default: return "PAUSE";
        endcase
    endfunction

    function automatic string glyph_str(input byte ch);
        case (ch)
            "L": return {"#....","#....","#....","#....","#....","#....","#####"};
            "O": return {".###.","#...#","#...#","#...#","#...#","#...#",".###."};
            "S": return {".####","#....","#....",".###.","....#","....#","####."};
            "E": return {"#####","#....","#....","####.","#....","#....","#####"};
            "R": return {"####.","#...#","#...#","####.","#.#..","#..#.","#...#"};
            "W": return {"#...#","#...#","#...#","#.#.#","#.#.#","#.#.#",".#.#."};
            "I": return {".###.","..#..","..#..","..#..","..#..","..#..",".###."};
            "N": return {"#...#","##..#","#.#.#","#..##","#...#","#...#","#...#"};
            "A": return {".###.","#...#","#...#","#####","#...#","#...#","#...#"};
            "D": return {"####.","#...#","#...#","#...#","#...#","#...#","####."};
            "Y": return {"#...#","#...#",".#.#.","..#..","..#..","..#..","..#.."};
            "P": return {"####.","#...#","#...#","####.","#....","#....","#...."};
            "U": return {"#...#","#...#","#...#","#...#","#...#","#...#",".###."};
            default: return {".....",".....",".....",".....",".....",".....","....."};
        endcase
    endfunction

    // Expected pixel stream of one full draw at default geometry
    task automatic push_draw(input int m, input bit lay, input logic [8:0] fg, input bit er);
        string txt;
        string g;
        byte   ch;
        bit    on;
        pix_t  p;
        txt = msg_text(m);
        for (int c = 0; c < 5; c++) begin
            ch = txt[c];
            g  = glyph_str(ch);
            for (int py = 0; py < 49; py++) begin
                for (int px = 0; px < 40; px++) begin
                    on = (g[(py / 7) * 5 + (px / 8)] == "#");
`ifdef BANNER_ERASE_EN
                    if (er) on = 1'b0;
`else
                    if (er) on = on;
`endif
                    p.x = 10'(120 + c * 80 + 20 + px);
                    p.y = 9'(200 + (lay ? 0 : c * 50) + py);
                    p.c = on ? fg : 9'd0;
                    exp_q.push_back(p);
                end
            end
        end
    endtask

    // Monitor: every write is popped against the scoreboard
    always @(negedge Clock) begin
        if (VGA_write === 1'b1) begin
            wr_count++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write got (%0d,%0d,%h) want no write", VGA_x, VGA_y, VGA_color);
            end else begin
                mon_e = exp_q.pop_front();
                if ({VGA_x, VGA_y, VGA_color} !== mon_e) begin
                    errors++;
                    $display("FAIL pixel got (%0d,%0d,%h) want (%0d,%0d,%h)",
                             VGA_x, VGA_y, VGA_color, mon_e.x, mon_e.y, mon_e.c);
                end
            end
            in_burst = 1'b1;
        end else begin
            if (in_burst && exp_q.size() != 0 && !abort_ok) begin
                checks++;
                errors++;
                $display("FAIL write_gap got VGA_write 0 want 1 (%0d pixels pending)", exp_q.size());
            end
            in_burst = 1'b0;
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, got, want);
        end
    endtask

    task automatic cyc();
        @(negedge Clock);
        #1;
    endtask

    // Raise enable with new request; check start latency and first pixel
    task automatic start_draw(input int m, input bit lay, input logic [8:0] fg, input bit er);
        msg_sel  = 2'(m);
        layout   = lay;
        fg_color = fg;
        erase    = er;
        push_draw(m, lay, fg, er);
        enable = 1'b1;
        cyc();
        chk("showing_after_start", 32'(showing), 32'd1);
        chk("no_write_at_start", 32'(VGA_write), 32'd0);
        cyc();
        chk("first_write", 32'(VGA_write), 32'd1);
        chk("first_x", 32'(VGA_x), 32'd140);
        chk("first_y", 32'(VGA_y), 32'd200);
        // Requests made mid-draw must be ignored
        msg_sel  = ~msg_sel;
        layout   = ~layout;
        fg_color = 9'h007;
        erase    = ~erase;
    endtask

    // Wait for the write count since base to reach n (bounded)
    task automatic wait_writes(input int base, input int n, input string name);
        int k;
        k = 0;
        while ((wr_count - base) < n && k < 12000) begin
            cyc();
            k++;
        end
        chk({name, "_reached"}, 32'(wr_count - base), 32'(n));
    endtask

    task automatic finish_draw();
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 12000) begin
            cyc();
            k++;
        end
        chk("draw_drained", 32'(exp_q.size()), 32'd0);
        cyc();
        chk("done_write_low", 32'(VGA_write), 32'd0);
        chk("done_complete", 32'(complete), 32'd1);
        chk("done_showing_low", 32'(showing), 32'd0);
    endtask

    initial begin
        int base;
        // Reset state
        repeat (3) cyc();
        chk("rst_showing", 32'(showing), 32'd0);
        chk("rst_complete", 32'(complete), 32'd0);
        chk("rst_write", 32'(VGA_write), 32'd0);
        chk("rst_xyc", {13'd0, VGA_x, VGA_y}, 32'd0);
        chk("rst_color", 32'(VGA_color), 32'd0);
        Resetn = 1'b1;
        repeat (2) cyc();

        // Staircase LOSER, first pixel and char 4 origin
        base = wr_count;
        start_draw(0, 1'b0, 9'h1C0, 1'b0);
        wait_writes(base, 7841, "char4");
        chk("char4_x", 32'(VGA_x), 32'd460);
        chk("char4_y", 32'(VGA_y), 32'd400);
        finish_draw();
        chk("t1_writes", 32'(wr_count - base), 32'd9800);
        enable = 1'b0;
        cyc();
        chk("t1_complete_drop", 32'(complete), 32'd0);

        // Horizontal "WIN  ": char 3 origin is background on row 200
        base = wr_count;
        start_draw(1, 1'b1, 9'h03F, 1'b0);
        wait_writes(base, 3 * 1960 + 1, "char3");
        chk("char3_x", 32'(VGA_x), 32'd380);
        chk("char3_y", 32'(VGA_y), 32'd200);
        chk("char3_bg", 32'(VGA_color), 32'd0);
        finish_draw();
        enable = 1'b0;
        cyc();

        // Abort after 100 writes, then full redraw
        base = wr_count;
        start_draw(2, 1'b0, 9'h0AA, 1'b0);
        wait_writes(base, 100, "abort");
        abort_ok = 1'b1;
        enable   = 1'b0;
        cyc();
        chk("abort_write_low", 32'(VGA_write), 32'd0);
        chk("abort_showing_low", 32'(showing), 32'd0);
        chk("abort_writes", 32'(wr_count - base), 32'd100);
        exp_q.delete();
        abort_ok = 1'b0;
        repeat (3) begin
            cyc();
            chk("abort_no_complete", 32'(complete), 32'd0);
        end
        base = wr_count;
        start_draw(2, 1'b0, 9'h0AA, 1'b0);
        finish_draw();
        chk("redraw_writes", 32'(wr_count - base), 32'd9800);

        // Hold enable in DONE: no restart, complete held
        repeat (50) begin
            cyc();
            chk("hold_complete", 32'(complete), 32'd1);
            chk("hold_no_write", 32'(VGA_write), 32'd0);
        end
        enable = 1'b0;
        cyc();
        chk("hold_complete_drop", 32'(complete), 32'd0);

        // Asynchronous reset mid-draw
        base = wr_count;
        start_draw(3, 1'b1, 9'h155, 1'b0);
        wait_writes(base, 50, "rst_mid");
        abort_ok = 1'b1;
        #2;
        Resetn = 1'b0;
        #1;
        chk("async_write", 32'(VGA_write), 32'd0);
        chk("async_showing", 32'(showing), 32'd0);
        chk("async_xy", {13'd0, VGA_x, VGA_y}, 32'd0);
        chk("async_color", 32'(VGA_color), 32'd0);
        exp_q.delete();
        repeat (2) cyc();
        Resetn = 1'b1;
        abort_ok = 1'b0;
        repeat (20) begin
            cyc();
            chk("post_rst_idle", {30'd0, showing, VGA_write}, 32'd0);
        end
        enable = 1'b0;
        cyc();

        // Erase request: background-only with the macro, glyphs without
        base = wr_count;
        start_draw(3, 1'b0, 9'h155, 1'b1);
        finish_draw();
        chk("erase_writes", 32'(wr_count - base), 32'd9800);
        enable = 1'b0;
        repeat (3) cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog got timeout want completion");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
